// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - twiddle mode constants and fixed-point helpers for SDF FFT stages
package fft_pkg;

    localparam int TW_NONE    = 0;
    localparam int TW_MINUS_J = 1;
    localparam int TW_ROM     = 2;

    typedef logic signed [63:0] wide_t;

    typedef struct packed {
        wide_t re;
        wide_t im;
    } cplx_t;

    function automatic wide_t sat_w(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic wide_t bf_scale(input wide_t v, input int w, input int scale);
        return (scale != 0) ? (v >>> 1) : sat_w(v, w);
    endfunction

    // x * (-j): (re, im) -> (im, -re); only the negation can overflow
    function automatic cplx_t rot_mj(input cplx_t x, input int w);
        cplx_t y;
        y.re = x.im;
        y.im = sat_w(-x.re, w);
        return y;
    endfunction

endpackage

// File: rtl/sdf_r2_stage_if.sv
// rtl/sdf_r2_stage_if.sv - streaming complex sample interface of one SDF stage
interface sdf_r2_stage_if #(
    parameter int W = 16
);
    logic                In_valid;
    logic                Flush;
    logic signed [W-1:0] Data_in_r;
    logic signed [W-1:0] Data_in_i;
    logic                Out_valid;
    logic                Frame_start;
    logic signed [W-1:0] Data_out_r;
    logic signed [W-1:0] Data_out_i;

    modport master (
        output In_valid, Flush, Data_in_r, Data_in_i,
        input  Out_valid, Frame_start, Data_out_r, Data_out_i
    );

    modport slave (
        input  In_valid, Flush, Data_in_r, Data_in_i,
        output Out_valid, Frame_start, Data_out_r, Data_out_i
    );
endinterface

// File: rtl/cmul_rnd.sv
// rtl/cmul_rnd.sv - registered complex multiply by a Q1.(TW_W-1) coefficient, round half-up, saturate
module cmul_rnd
    import fft_pkg::*;
#(
    parameter int W    = 16,
    parameter int TW_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   en,
    input  logic signed [W-1:0]    x_r,
    input  logic signed [W-1:0]    x_i,
    input  logic signed [TW_W-1:0] tw_r,
    input  logic signed [TW_W-1:0] tw_i,
    output logic signed [W-1:0]    y_r,
    output logic signed [W-1:0]    y_i
);
    localparam wide_t HALF = wide_t'(1) <<< (TW_W - 2);

    wide_t p_r;
    wide_t p_i;

    assign p_r = wide_t'(x_r) * wide_t'(tw_r) - wide_t'(x_i) * wide_t'(tw_i);
    assign p_i = wide_t'(x_r) * wide_t'(tw_i) + wide_t'(x_i) * wide_t'(tw_r);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_r <= '0;
            y_i <= '0;
        end else if (en) begin
            y_r <= W'(sat_w((p_r + HALF) >>> (TW_W - 1), W));
            y_i <= W'(sat_w((p_i + HALF) >>> (TW_W - 1), W));
        end
    end
endmodule

// File: rtl/sdf_r2_stage.sv
// rtl/sdf_r2_stage.sv - radix-2 single-path delay-feedback FFT stage
module sdf_r2_stage
    import fft_pkg::*;
#(
    parameter int  W       = 16,
    parameter int  DEPTH   = 128,
    parameter int  TW_MODE = TW_NONE,
    parameter int  TW_W    = 16,
    parameter int  SCALE   = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    sdf_r2_stage_if.slave          s,
    output logic [AW-1:0]          Tw_addr,
    input  logic signed [TW_W-1:0] Tw_r,
    input  logic signed [TW_W-1:0] Tw_i
);
    localparam int CW = $clog2(2 * DEPTH);

    logic [CW-1:0]       cnt;
    logic [AW-1:0]       j;
    logic                phase_b;
    logic                adv;
    logic                primed;
    logic [2*W-1:0]      dly [DEPTH];
    logic [2*W-1:0]      rd;
    logic [2*W-1:0]      wr;
    logic signed [W-1:0] x_r, x_i, a_r, a_i;
    logic signed [W-1:0] sum_r, sum_i, dif_r, dif_i;
    logic signed [W-1:0] e_r, e_i, f_r, f_i;
    cplx_t               rot;
    logic                rot_sel;
    logic                e_valid, e_fs, e_mul;
    logic                f_valid, f_fs;
    logic                unused_rot;

    if (DEPTH > 1) begin : g_j
        assign j = cnt[AW-1:0];
    end else begin : g_j1
        assign j = '0;
    end

    assign phase_b = cnt[CW-1];
    assign adv     = s.In_valid | (s.Flush & primed & ~phase_b);
    assign Tw_addr = j;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (adv) begin
            cnt <= cnt + CW'(1);
            if (phase_b) primed <= 1'b1;
        end
    end

    // Delay RAM is deliberately left out of reset; phase A always rewrites it before use
    always_ff @(posedge CLK) begin
        if (adv) dly[j] <= wr;
    end
    assign rd = dly[j];

    assign x_r = s.In_valid ? s.Data_in_r : '0;
    assign x_i = s.In_valid ? s.Data_in_i : '0;
    assign a_r = rd[2*W-1:W];
    assign a_i = rd[W-1:0];

    assign sum_r = W'(bf_scale(wide_t'(a_r) + wide_t'(x_r), W, SCALE));
    assign sum_i = W'(bf_scale(wide_t'(a_i) + wide_t'(x_i), W, SCALE));
    assign dif_r = W'(bf_scale(wide_t'(a_r) - wide_t'(x_r), W, SCALE));
    assign dif_i = W'(bf_scale(wide_t'(a_i) - wide_t'(x_i), W, SCALE));
    assign wr    = phase_b ? {dif_r, dif_i} : {x_r, x_i};

    assign rot        = rot_mj({wide_t'(a_r), wide_t'(a_i)}, W);
    assign unused_rot = ^{rot.re[63:W], rot.im[63:W]};
    assign rot_sel    = (TW_MODE == TW_MINUS_J) && !phase_b && j[AW-1];

    always_comb begin
        e_r = a_r;
        e_i = a_i;
        if (phase_b) begin
            e_r = sum_r;
            e_i = sum_i;
        end else if (rot_sel) begin
            e_r = W'(rot.re);
            e_i = W'(rot.im);
        end
    end

    assign e_valid = adv & (primed | phase_b);
    assign e_fs    = (cnt == CW'(DEPTH));
    assign e_mul   = (TW_MODE == TW_ROM) && !phase_b && (j != '0);

    if (TW_MODE == TW_ROM) begin : g_rom
        logic signed [W-1:0] m_r, m_i, p_r, p_i;
        logic                p_valid, p_fs, p_mul;

        cmul_rnd #(.W(W), .TW_W(TW_W)) u_cmul (
            .CLK  (CLK),
            .RST_N(RST_N),
            .en   (e_valid & e_mul),
            .x_r  (a_r),
            .x_i  (a_i),
            .tw_r (Tw_r),
            .tw_i (Tw_i),
            .y_r  (m_r),
            .y_i  (m_i)
        );

        // Sum and bypass samples ride this register so every output sees the multiplier latency
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                p_valid <= 1'b0;
                p_fs    <= 1'b0;
                p_mul   <= 1'b0;
                p_r     <= '0;
                p_i     <= '0;
            end else begin
                p_valid <= e_valid;
                p_fs    <= e_fs;
                p_mul   <= e_mul;
                if (e_valid) begin
                    p_r <= e_r;
                    p_i <= e_i;
                end
            end
        end

        assign f_valid = p_valid;
        assign f_fs    = p_fs;
        assign f_r     = p_mul ? m_r : p_r;
        assign f_i     = p_mul ? m_i : p_i;
    end else begin : g_direct
        logic unused_tw;
        assign unused_tw = ^{Tw_r, Tw_i, e_mul};
        assign f_valid   = e_valid;
        assign f_fs      = e_fs;
        assign f_r       = e_r;
        assign f_i       = e_i;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s.Out_valid   <= 1'b0;
            s.Frame_start <= 1'b0;
            s.Data_out_r  <= '0;
            s.Data_out_i  <= '0;
        end else begin
            s.Out_valid   <= f_valid;
            s.Frame_start <= f_valid & f_fs;
            if (f_valid) begin
                s.Data_out_r <= f_r;
                s.Data_out_i <= f_i;
            end
        end
    end
endmodule

// File: tb/tb_sdf_r2_stage.sv
// tb/tb_sdf_r2_stage.sv - directed self-checking bench for sdf_r2_stage (W=16, DEPTH=4)
module tb_sdf_r2_stage;

    typedef struct {
        int                 cyc;
        logic               fs;
        logic signed [15:0] r;
        logic signed [15:0] i;
    } rec_t;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               in_valid = 1'b0;
    logic               flush    = 1'b0;
    logic signed [15:0] din_r    = '0;
    logic signed [15:0] din_i    = '0;
    logic signed [15:0] tw_r     = 16'sh4000;
    logic signed [15:0] tw_i     = '0;
    logic [1:0]         ta0, ta1, ta2, ta3;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   t5     = 0;
    int   er [4][8];
    int   ei [4][8];
    int   t4v [8];
    rec_t q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdf_r2_stage_if #(.W(16)) b0 ();
    sdf_r2_stage_if #(.W(16)) b1 ();
    sdf_r2_stage_if #(.W(16)) b2 ();
    sdf_r2_stage_if #(.W(16)) b3 ();

    assign {b0.In_valid, b0.Flush, b0.Data_in_r, b0.Data_in_i} = {in_valid, flush, din_r, din_i};
    assign {b1.In_valid, b1.Flush, b1.Data_in_r, b1.Data_in_i} = {in_valid, flush, din_r, din_i};
    assign {b2.In_valid, b2.Flush, b2.Data_in_r, b2.Data_in_i} = {in_valid, flush, din_r, din_i};
    assign {b3.In_valid, b3.Flush, b3.Data_in_r, b3.Data_in_i} = {in_valid, flush, din_r, din_i};

    sdf_r2_stage #(.W(16), .DEPTH(4), .TW_MODE(0), .TW_W(16), .SCALE(0)) dut0 (
        .CLK(clk), .RST_N(rst_n), .s(b0), .Tw_addr(ta0), .Tw_r(tw_r), .Tw_i(tw_i));
    sdf_r2_stage #(.W(16), .DEPTH(4), .TW_MODE(1), .TW_W(16), .SCALE(0)) dut1 (
        .CLK(clk), .RST_N(rst_n), .s(b1), .Tw_addr(ta1), .Tw_r(tw_r), .Tw_i(tw_i));
    sdf_r2_stage #(.W(16), .DEPTH(4), .TW_MODE(2), .TW_W(16), .SCALE(0)) dut2 (
        .CLK(clk), .RST_N(rst_n), .s(b2), .Tw_addr(ta2), .Tw_r(tw_r), .Tw_i(tw_i));
    sdf_r2_stage #(.W(16), .DEPTH(4), .TW_MODE(0), .TW_W(16), .SCALE(1)) dut3 (
        .CLK(clk), .RST_N(rst_n), .s(b3), .Tw_addr(ta3), .Tw_r(tw_r), .Tw_i(tw_i));

    always @(negedge clk) if (b0.Out_valid) q0.push_back('{cyc, b0.Frame_start, b0.Data_out_r, b0.Data_out_i});
    always @(negedge clk) if (b1.Out_valid) q1.push_back('{cyc, b1.Frame_start, b1.Data_out_r, b1.Data_out_i});
    always @(negedge clk) if (b2.Out_valid) q2.push_back('{cyc, b2.Frame_start, b2.Data_out_r, b2.Data_out_i});
    always @(negedge clk) if (b3.Out_valid) q3.push_back('{cyc, b3.Frame_start, b3.Data_out_r, b3.Data_out_i});

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int n);
        rec_t qq[$];
        case (n)
            0:       qq = q0;
            1:       qq = q1;
            2:       qq = q2;
            default: qq = q3;
        endcase
        chk($sformatf("%s.d%0d.count", tag, n), qq.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < qq.size()) begin
                chk($sformatf("%s.d%0d[%0d].re", tag, n, k), int'(qq[k].r), er[n][k]);
                chk($sformatf("%s.d%0d[%0d].im", tag, n, k), int'(qq[k].i), ei[n][k]);
                chk($sformatf("%s.d%0d[%0d].fs", tag, n, k), int'(qq[k].fs), (k == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic chk_all(input string tag);
        for (int n = 0; n < 4; n++) chk_q(tag, n);
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
    endtask

    task automatic step(input logic v, input int r, input logic f);
        in_valid = v;
        din_r    = 16'(r);
        din_i    = '0;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
    endtask

    // inputs 1..8, five Flush requests (the fifth lands in phase B), three idle cycles
    task automatic run_t1(input logic gaps);
        if (gaps) step(1'b0, 0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, k, gaps);
            if (k == 2) chk("tw_addr_j2", int'(ta2), 2);
            if (k == 5) t5 = cyc;
            if (gaps) begin
                step(1'b0, 0, 1'b0);
                step(1'b0, 0, 1'b0);
            end
        end
        for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0);
    endtask

    task automatic set_t1_exp();
        er = '{'{6, 8, 10, 12, -4, -4, -4, -4},
               '{6, 8, 10, 12, -4, -4,  0,  0},
               '{6, 8, 10, 12, -4, -2, -2, -2},
               '{3, 4,  5,  6, -2, -2, -2, -2}};
        ei = '{'{0, 0, 0, 0, 0, 0, 0, 0},
               '{0, 0, 0, 0, 0, 0, 4, 4},
               '{0, 0, 0, 0, 0, 0, 0, 0},
               '{0, 0, 0, 0, 0, 0, 0, 0}};
    endtask

    task automatic set_t4_exp();
        er = '{'{32767, -1, -1, 0, 0, -32768, -32768, 0},
               '{32767, -1, -1, 0, 0, -32768,      0, 0},
               '{32767, -1, -1, 0, 0, -16384, -16384, 0},
               '{32767, -1, -1, 0, 0, -32768, -32768, 0}};
        ei = '{'{0, 0, 0, 0, 0, 0,     0, 0},
               '{0, 0, 0, 0, 0, 0, 32767, 0},
               '{0, 0, 0, 0, 0, 0,     0, 0},
               '{0, 0, 0, 0, 0, 0,     0, 0}};
    endtask

    initial begin
        t4v = '{32767, -32768, -32768, 0, 32767, 32767, 32767, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.d0.out_valid", int'(b0.Out_valid), 0);
        chk("rst.d0.frame_start", int'(b0.Frame_start), 0);
        chk("rst.d0.data_r", int'(b0.Data_out_r), 0);
        chk("rst.d2.out_valid", int'(b2.Out_valid), 0);
        chk("rst.d2.data_i", int'(b2.Data_out_i), 0);
        chk("rst.d2.tw_addr", int'(ta2), 0);
        rst_n = 1'b1;

        set_t1_exp();
        run_t1(1'b0);
        chk_all("t1");
        if (q0.size() > 4 && q2.size() > 4) begin
            chk("t1.lat_d0", q0[0].cyc, t5);
            chk("t1.lat_d2", q2[0].cyc, t5 + 1);
            chk("t1.lat_d2_diff", q2[4].cyc, q0[4].cyc + 1);
        end

        do_reset();
        set_t4_exp();
        for (int k = 0; k < 8; k++) step(1'b1, t4v[k], 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0);
        chk_all("t4");

        do_reset();
        for (int k = 1; k <= 6; k++) step(1'b1, k, 1'b0);
        chk("t5.pre.d0.out_valid", int'(b0.Out_valid), 1);
        chk("t5.pre.d2.out_valid", int'(b2.Out_valid), 1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("t5.rst.d0.out_valid", int'(b0.Out_valid), 0);
        chk("t5.rst.d2.out_valid", int'(b2.Out_valid), 0);
        chk("t5.rst.d0.data_r", int'(b0.Data_out_r), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
        set_t1_exp();
        run_t1(1'b0);
        chk_all("t5");

        do_reset();
        run_t1(1'b1);
        chk_all("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
